// File: rtl/sw_max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sw_max_tracker
// Description : Tracks the best local-alignment score and its (row, col)
//               position across the sw_pe lanes for one query pass.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_max_tracker #(
    parameter int NUM_PE = 8,
    parameter int ROW_W  = 3,
    parameter int LEN_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     query_len,
    input  logic [NUM_PE*16-1:0] scores_i,
    input  logic [NUM_PE-1:0]    valid_i,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [15:0]          max_score,
    output logic [ROW_W-1:0]     max_row,
    output logic [LEN_W-1:0]     max_col
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt [NUM_PE];
    logic [NUM_PE-1:0]  w_accept;
    logic               w_start_pass;

    logic               w_best_v;
    logic [15:0]        w_best_score;
    logic [ROW_W-1:0]   w_best_row;
    logic [LEN_W-1:0]   w_best_col;

    logic               r_cand_v;
    logic [15:0]        r_cand_score;
    logic [ROW_W-1:0]   r_cand_row;
    logic [LEN_W-1:0]   r_cand_col;

    logic [15:0]        r_max_score;
    logic [ROW_W-1:0]   r_max_row;
    logic [LEN_W-1:0]   r_max_col;

    assign w_start_pass = (r_state == S_IDLE) && start;

    for (genvar k = 0; k < NUM_PE; k++) begin : g_accept
        assign w_accept[k] = (r_state == S_RUN) && valid_i[k] && (r_cnt[k] < r_len);
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_pass) begin
            for (int k = 0; k < NUM_PE; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (w_accept[k]) r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= '0;
        end else if (w_start_pass) begin
            r_len <= query_len;
        end
    end

    // Strict compare while scanning upward keeps the lowest lane on ties.
    always_comb begin
        w_best_v     = 1'b0;
        w_best_score = '0;
        w_best_row   = '0;
        w_best_col   = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (w_accept[k] && (!w_best_v || (scores_i[16*k +: 16] > w_best_score))) begin
                w_best_v     = 1'b1;
                w_best_score = scores_i[16*k +: 16];
                w_best_row   = ROW_W'(k);
                w_best_col   = r_cnt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_pass) begin
            r_cand_v     <= 1'b0;
            r_cand_score <= '0;
            r_cand_row   <= '0;
            r_cand_col   <= '0;
        end else begin
            r_cand_v     <= w_best_v;
            r_cand_score <= w_best_score;
            r_cand_row   <= w_best_row;
            r_cand_col   <= w_best_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_pass) begin
            r_max_score <= '0;
            r_max_row   <= '0;
            r_max_col   <= '0;
        end else if (r_cand_v && (r_cand_score > r_max_score)) begin
            r_max_score <= r_cand_score;
            r_max_row   <= r_cand_row;
            r_max_col   <= r_cand_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN ends one cycle after the last lane saturates so the final
    // candidate reaches stage B during DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (query_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (r_cnt[NUM_PE-1] == r_len) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  if (result_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign result_valid = (r_state == S_DONE);
    assign max_score    = r_max_score;
    assign max_row      = r_max_row;
    assign max_col      = r_max_col;

endmodule
`default_nettype wire

// File: tb/tb_sw_max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_max_tracker
// Description : Randomized and directed bench for sw_max_tracker with a
//               plan-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_max_tracker;

    localparam int NUM_PE = 8;
    localparam int ROW_W  = 3;
    localparam int LEN_W  = 10;
    localparam int MAXC   = 128;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LEN_W-1:0]     query_len;
    logic [NUM_PE*16-1:0] scores_i;
    logic [NUM_PE-1:0]    valid_i;
    logic                 busy;
    logic                 result_valid;
    logic                 result_ready;
    logic [15:0]          max_score;
    logic [ROW_W-1:0]     max_row;
    logic [LEN_W-1:0]     max_col;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus plan: cycles 0..p_ncyc-1 end with lane NUM_PE-1's final beat;
    // cycle p_ncyc carries only possible overrun beats on that lane.
    logic [NUM_PE-1:0] p_vld [MAXC];
    logic [15:0]       p_sc  [MAXC][NUM_PE];
    int                p_ncyc;
    int                exp_score, exp_row, exp_col;

    always #5 clk = ~clk;

    sw_max_tracker #(.NUM_PE(NUM_PE), .ROW_W(ROW_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .query_len    (query_len),
        .scores_i     (scores_i),
        .valid_i      (valid_i),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .max_score    (max_score),
        .max_row      (max_row),
        .max_col      (max_col)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(input int c);
        valid_i = p_vld[c];
        for (int k = 0; k < NUM_PE; k++) scores_i[16*k +: 16] = p_sc[c][k];
    endtask

    // Beats outside RUN must be ignored, so make them large enough to show.
    task automatic drive_garbage();
        valid_i = NUM_PE'($urandom);
        for (int k = 0; k < NUM_PE; k++) scores_i[16*k +: 16] = 16'($urandom_range(1000, 60000));
    endtask

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            p_vld[c] = '0;
            for (int k = 0; k < NUM_PE; k++) p_sc[c][k] = '0;
        end
        p_ncyc = 0;
    endtask

    task automatic fill_full(input int len, input int smax);
        clear_plan();
        for (int c = 0; c < len; c++) begin
            p_vld[c] = '1;
            for (int k = 0; k < NUM_PE; k++) p_sc[c][k] = 16'($urandom_range(0, smax));
        end
        p_ncyc = len;
    endtask

    task automatic gen_random(input int len, input int smax);
        int c;
        int n7;
        clear_plan();
        c  = 0;
        n7 = 0;
        while (n7 < len) begin
            for (int k = 0; k < NUM_PE - 1; k++) begin
                p_vld[c][k] = ($urandom_range(0, 3) != 0);
                p_sc[c][k]  = 16'($urandom_range(0, smax));
            end
            p_vld[c][NUM_PE-1] = (c >= 60) || ($urandom_range(0, 1) == 1);
            p_sc[c][NUM_PE-1]  = 16'($urandom_range(0, smax));
            if (p_vld[c][NUM_PE-1]) n7++;
            c++;
        end
        p_ncyc = c;
        p_vld[c][NUM_PE-1] = ($urandom_range(0, 1) == 1);
        p_sc[c][NUM_PE-1]  = 16'(smax + 100);
    endtask

    // Best score is the first occurrence in (cycle, lane) order among each
    // lane's first len beats.
    function automatic void model(input int len);
        int cnt [NUM_PE];
        exp_score = 0;
        exp_row   = 0;
        exp_col   = 0;
        for (int k = 0; k < NUM_PE; k++) cnt[k] = 0;
        for (int c = 0; c <= p_ncyc; c++) begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (p_vld[c][k] && cnt[k] < len) begin
                    if (int'(p_sc[c][k]) > exp_score) begin
                        exp_score = int'(p_sc[c][k]);
                        exp_row   = k;
                        exp_col   = cnt[k];
                    end
                    cnt[k]++;
                end
            end
        end
    endfunction

    task automatic run_pass(input int len, input int hold, input int e_s, input int e_r, input int e_c);
        model(len);
        if (e_s >= 0) begin
            exp_score = e_s;
            exp_row   = e_r;
            exp_col   = e_c;
        end
        valid_i   = '0;
        start     = 1'b1;
        query_len = LEN_W'(len);
        tick();
        start = 1'b0;
        if (len == 0) begin
            check_eq("zero_len_valid", int'(result_valid), 1);
        end else begin
            check_eq("run_busy", int'(busy), 1);
            for (int c = 0; c < p_ncyc; c++) begin
                drive_cycle(c);
                tick();
            end
            drive_cycle(p_ncyc);
            tick();
            check_eq("drain_no_result", int'(result_valid), 0);
            check_eq("drain_busy", int'(busy), 1);
            drive_garbage();
            start = 1'b1;
            tick();
            start = 1'b0;
            check_eq("result_latency", int'(result_valid), 1);
        end
        check_eq("done_busy", int'(busy), 0);
        check_eq("max_score", int'(max_score), exp_score);
        check_eq("max_row", int'(max_row), exp_row);
        check_eq("max_col", int'(max_col), exp_col);
        for (int h = 0; h < hold; h++) begin
            drive_garbage();
            start = 1'($urandom_range(0, 1));
            tick();
            check_eq("hold_valid", int'(result_valid), 1);
            check_eq("hold_busy", int'(busy), 0);
            check_eq("hold_score", int'(max_score), exp_score);
            check_eq("hold_pos", int'(max_row) * 4096 + int'(max_col), exp_row * 4096 + exp_col);
        end
        result_ready = 1'b1;
        start        = 1'b1;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        valid_i      = '0;
        check_eq("accept_drop", int'(result_valid), 0);
        tick();
        check_eq("accept_start_ignored", int'(busy), 0);
        check_eq("accept_idle_valid", int'(result_valid), 0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        valid_i      = '0;
        scores_i     = '0;
        query_len    = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_valid", int'(result_valid), 0);
        check_eq("rst_score", int'(max_score), 0);
        check_eq("rst_row", int'(max_row), 0);
        check_eq("rst_col", int'(max_col), 0);

        // Single peak on lane 3, beat 2
        fill_full(4, 5);
        p_sc[2][3] = 16'd9;
        run_pass(4, 0, 9, 3, 2);

        // Same-cycle tie on lanes 1/5, later equal score on lane 6
        fill_full(4, 5);
        p_sc[1][1] = 16'd7;
        p_sc[1][5] = 16'd7;
        p_sc[2][6] = 16'd7;
        run_pass(4, 0, 7, 1, 1);

        // Zero-length pass with beats arriving while idle
        for (int i = 0; i < 3; i++) begin
            drive_garbage();
            tick();
        end
        clear_plan();
        run_pass(0, 3, 0, 0, 0);

        // Overrun on the last lane carries a large score that must drop
        fill_full(4, 7);
        p_sc[1][2] = 16'd8;
        p_vld[4][NUM_PE-1] = 1'b1;
        p_sc[4][NUM_PE-1]  = 16'd20;
        run_pass(4, 0, 8, 2, 1);

        // Backpressure, then a normal pass
        gen_random(6, 30);
        run_pass(6, 10, -1, 0, 0);
        gen_random(5, 30);
        run_pass(5, 0, -1, 0, 0);

        // Reset mid-pass after two large beats
        start     = 1'b1;
        query_len = LEN_W'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_i = '1;
            for (int k = 0; k < NUM_PE; k++) scores_i[16*k +: 16] = 16'd500;
            tick();
        end
        valid_i = '0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_valid", int'(result_valid), 0);
        check_eq("midrst_score", int'(max_score), 0);
        check_eq("midrst_pos", int'(max_row) * 4096 + int'(max_col), 0);
        gen_random(4, 40);
        run_pass(4, 0, -1, 0, 0);

        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(1, 20);
            gen_random(len, (p % 2 == 0) ? 15 : 65535 - 200);
            run_pass(len, $urandom_range(0, 3), -1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
